pump_speed_sequencer: RTL

Parametrised successor to the single-button pump speed control.
- Accepts independent debounced up/down buttons, with wrap or saturate at the ends of an N-level range.
- Maps the level to a PWM duty, ramps duty gradually toward target, and drives the pump PWM output.
- Sits between the board push-buttons / flood-alarm logic and the pump driver pin.
- Also exports the level for the display.

---
 rtl/pump_speed_sequencer_pkg.sv | 20 ++
 rtl/pump_speed_sequencer_debounce.sv | 50 +++++
 rtl/pump_speed_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pump_speed_sequencer_pkg.sv
// Shared types and elaboration-time helpers for the pump speed sequencer.
// Ramp state encoding plus debounce-length and duty-table helpers.
package pump_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } ramp_state_e;

    function automatic int db_cnt(input int clk_hz, input int debounce_ms);
        return clk_hz / 1000 * debounce_ms;
    endfunction

    // Evenly spread levels over the full duty range, floor rounding.
    function automatic int duty_lut(input int lvl, input int num_levels, input int pwm_w);
        return lvl * ((1 << pwm_w) - 1) / (num_levels - 1);
    endfunction

endpackage

// File: rtl/pump_speed_sequencer_debounce.sv
// Button debouncer: 2-FF synchroniser, stable-time counter, rising-press pulse.
module key_debounce
    import pump_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20
)
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic stable
);

    localparam int DB_CNT = db_cnt(CLK_HZ, DEBOUNCE_MS);
    localparam int CW     = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DB_CNT - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_TC) begin
                cnt_q    <= '0;
                stable_q <= sync2_q;
                press_q  <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press  = press_q;
    assign stable = stable_q;

endmodule

// File: rtl/pump_speed_sequencer.sv
// Pump speed sequencer: up/down level select, duty LUT, optional soft ramp, PWM.
// Define PUMP_SOFT_RAMP_EN to build the ramp FSM; otherwise duty follows target directly.
//
// state   | meaning
// IDLE    | duty equals target, waiting for a target change
// RAMP_UP | stepping duty up one LSB every RAMP_DIV clocks
// RAMP_DN | stepping duty down one LSB every RAMP_DIV clocks
module pump_speed_sequencer
    import pump_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int NUM_LEVELS  = 4,
    parameter int LVL_W       = 2,
    parameter int PWM_W       = 8,
    parameter int WRAP        = 1,
    parameter int RAMP_DIV    = 50000
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_dn,
    input  logic             enable,
    input  logic             force_max,
    output logic [LVL_W-1:0] level,
    output logic [PWM_W-1:0] duty,
    output logic             pwm_out,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [PWM_W-1:0] DUTY_FULL = '1;

    logic             up_p, dn_p;
    logic [1:0]       stable_unused;
    logic [LVL_W-1:0] level_q, level_d;
    logic [PWM_W-1:0] duty_q, duty_d, target;
    logic [PWM_W-1:0] cnt_q;
    logic             pwm_q;
    logic [PWM_W-1:0] lut [2**LVL_W];

    key_debounce #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
        .clk(clk), .rst(rst), .btn(btn_up), .press(up_p), .stable(stable_unused[0])
    );
    key_debounce #(.CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS)) u_db_dn (
        .clk(clk), .rst(rst), .btn(btn_dn), .press(dn_p), .stable(stable_unused[1])
    );

    // Alarm discards presses outright; simultaneous up+dn cancel.
    always_comb begin
        level_d = level_q;
        if (!force_max && (up_p != dn_p)) begin
            if (up_p) begin
                if (level_q == LVL_MAX) level_d = (WRAP != 0) ? '0 : level_q;
                else                    level_d = level_q + 1'b1;
            end else begin
                if (level_q == '0)      level_d = (WRAP != 0) ? LVL_MAX : level_q;
                else                    level_d = level_q - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < 2**LVL_W; i++) begin : g_lut
        localparam int V = (i < NUM_LEVELS) ? duty_lut(i, NUM_LEVELS, PWM_W) : 0;
        assign lut[i] = PWM_W'(V);
    end

    always_comb begin
        if (!enable)        target = '0;
        else if (force_max) target = DUTY_FULL;
        else                target = lut[level_q];
    end

`ifdef PUMP_SOFT_RAMP_EN
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(RAMP_DIV - 1);

    ramp_state_e      state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [PWM_W-1:0] step;

    // Direction is re-evaluated every cycle, so a target move reverses without IDLE.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        duty_d  = duty_q;
        step    = (state_q == RAMP_UP) ? duty_q + 1'b1 : duty_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (target != duty_q) begin
                    pre_d = '0;
                    if (target > duty_q) state_d = RAMP_UP;
                    else                 state_d = RAMP_DN;
                end
            end
            RAMP_UP, RAMP_DN: begin
                if (target == duty_q) begin
                    state_d = IDLE;
                end else if ((target > duty_q) != (state_q == RAMP_UP)) begin
                    pre_d = '0;
                    if (target > duty_q) state_d = RAMP_UP;
                    else                 state_d = RAMP_DN;
                end else if (pre_q == PRE_TC) begin
                    pre_d  = '0;
                    duty_d = step;
                    if (step == target) state_d = IDLE;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end
`else
    localparam int RAMP_DIV_UNUSED = RAMP_DIV;

    always_comb duty_d = target;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
            duty_q  <= '0;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_q + 1'b1;
            pwm_q   <= (cnt_q < duty_q);
        end
    end

    assign level   = level_q;
    assign duty    = duty_q;
    assign pwm_out = pwm_q;
    assign at_max  = (level_q == LVL_MAX);
    assign at_min  = (level_q == '0);

endmodule
